dotn_mac: RTL

Parametrised N-element signed fixed-point dot product engine. It is the next-generation replacement for the fixed 4-element Q8.8 dot unit in the vertex/shading path. It generalises element count, word width and fractional bits, and adds three things the old unit lacked: full-precision accumulation with a single final truncation, optional saturation with an overflow flag, and an accumulate-into-previous-result mode. It processes one element per cycle with a sequential state machine and a start/busy/done handshake.

---
 rtl/dotn_mac.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dotn_mac.sv
// dotn_mac: sequential signed fixed-point dot product, one element per cycle.
// The sum is kept at full precision and truncated once (floor) at the end.
// On overflow the result either saturates or wraps, selected by SAT.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start_i; result_o/overflow_o hold the last value
// S_MAC   | accumulate v1[k]*v2[k], k = 0..N-1
// S_FINAL | shift, range-check, then saturate or wrap; write result, pulse done
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     operation request, accepted only while busy_o = 0
//   accum_i     sampled with start_i: seed the sum with the current result
//   v1_i, v2_i  N packed W-bit two's complement vectors, element i at [i*W +: W]
//   busy_o      operation in progress
//   done_o      one-cycle pulse when result_o/overflow_o are updated
//   result_o    W-bit signed dot product
//   overflow_o  final value was outside the W-bit signed range
module dotn_mac #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int F   = 8,
    parameter int SAT = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic           accum_i,
    input  logic [N*W-1:0] v1_i,
    input  logic [N*W-1:0] v2_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [W-1:0]   result_o,
    output logic           overflow_o
);

    // Wide enough that N full-precision products plus a seeded result never overflow.
    localparam int AW = 2*W + $clog2(N) + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FINAL
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [N*W-1:0]        v1_q, v1_d;
    logic [N*W-1:0]        v2_q, v2_d;
    logic [W-1:0]          result_q, result_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;

    logic signed [W-1:0]   a_el, b_el;
    logic signed [2*W-1:0] prod;
    logic [AW-1:0]         prod_ext;
    logic [AW-1:0]         seed;
    logic signed [AW-1:0]  s;
    logic [AW-W:0]         s_upper;
    logic                  in_range;

    assign a_el     = v1_q[k_q*W +: W];
    assign b_el     = v2_q[k_q*W +: W];
    assign prod     = a_el * b_el;
    assign prod_ext = {{(AW-2*W){prod[2*W-1]}}, prod};
    assign seed     = {{(AW-W){result_q[W-1]}}, result_q} << F;

    // s fits in W bits only when every bit from the W-1 sign position upwards agrees.
    assign s        = acc_q >>> F;
    assign s_upper  = s[AW-1:W-1];
    assign in_range = (&s_upper) | ~(|s_upper);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    v1_d    = v1_i;
                    v2_d    = v2_i;
                    k_d     = '0;
                    acc_d   = accum_i ? seed : '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(N-1)) begin
                    k_d     = '0;
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                overflow_d = ~in_range;
                if (in_range || SAT == 0) begin
                    result_d = s[W-1:0];
                end else if (s[AW-1]) begin
                    result_d = {1'b1, {(W-1){1'b0}}};
                end else begin
                    result_d = {1'b0, {(W-1){1'b1}}};
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            acc_q      <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = overflow_q;

endmodule
